// File: rtl/updown_driver.sv
`default_nettype none
// ============================================================================
// Module      : updown_driver
// Description : Drives an external up/down counter that moves on every clock
//               edge unless reset. Keeps a shadow copy of the counter value,
//               dithers (+1/-1) around the held value when idle, and runs the
//               counter to an accepted target value, pulsing done on arrival.
//               A clear request zeroes the counter, aborting any run.
//
// Ports       : clock        - rising-edge clock
//               reset        - asynchronous active-low reset
//               target_valid / target_data / target_ready
//                            - target request handshake
//               clear / clear_ready
//                            - zero-the-counter handshake (wins over target)
//               ctr_reset    - synchronous active-high reset to the counter
//               ctr_inst     - counter instruction: 0 = up, 1 = down
//               shadow       - counter value after the most recent edge
//               busy         - high in INIT, CLR and RUN
//               done         - one-cycle pulse when shadow reaches the target
//               run_steps    - counting cycles of the last/current run
//
// Config      : `define SHORTEST_PATH_EN to choose the shorter modular
//               direction (runs may wrap through 0; ties go up). Undefined:
//               plain unsigned compare, never wraps.
//
// Revision    : 1.0 - initial release
// ============================================================================
module updown_driver #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             target_valid,
   input  logic [WIDTH-1:0] target_data,
   output logic             target_ready,
   input  logic             clear,
   output logic             clear_ready,
   output logic             ctr_reset,
   output logic             ctr_inst,
   output logic [WIDTH-1:0] shadow,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] run_steps
);

   typedef enum logic [1:0] {
      ST_INIT = 2'd0,
      ST_HOLD = 2'd1,
      ST_CLR  = 2'd2,
      ST_RUN  = 2'd3
   } state_t;

   localparam logic [WIDTH-1:0] C_STEPS_MAX = '1;

   state_t           r_state;
   logic             r_phase;
   logic [WIDTH-1:0] r_shadow;
   logic [WIDTH-1:0] r_target;
   logic [WIDTH-1:0] r_run_steps;

   logic w_at_target;
   logic w_dir_down;
   logic w_ctr_reset;
   logic w_ctr_inst;
   logic w_target_ready;
   logic w_clear_ready;
   logic w_busy;
   logic w_done;
   logic w_clear_acc;
   logic w_target_acc;

   assign w_at_target = (r_shadow == r_target);

`ifdef SHORTEST_PATH_EN
   logic [WIDTH-1:0] w_up_dist;
   logic [WIDTH-1:0] w_dn_dist;

   // Modular distances in each direction; equal distances resolve upward.
   assign w_up_dist  = r_target - r_shadow;
   assign w_dn_dist  = r_shadow - r_target;
   assign w_dir_down = (w_up_dist > w_dn_dist);
`else
   assign w_dir_down = !(r_target > r_shadow);
`endif

   // Counter control and handshake flags depend only on registered state,
   // so exactly one of reset/up/down is driven every cycle.
   always_comb begin
      w_ctr_reset    = 1'b0;
      w_ctr_inst     = 1'b0;
      w_target_ready = 1'b0;
      w_clear_ready  = 1'b0;
      w_busy         = 1'b1;
      w_done         = 1'b0;
      case (r_state)
         ST_INIT: begin
            w_ctr_reset = 1'b1;
         end
         ST_HOLD: begin
            w_busy         = 1'b0;
            w_ctr_inst     = r_phase;
            w_target_ready = !r_phase;
            w_clear_ready  = !r_phase;
         end
         ST_CLR: begin
            w_ctr_reset = 1'b1;
         end
         ST_RUN: begin
            w_clear_ready = 1'b1;
            if (w_at_target) begin
               // Arrival step goes up; HOLD phase 1 then steps back down.
               w_done     = 1'b1;
               w_ctr_inst = 1'b0;
            end else begin
               w_ctr_inst = w_dir_down;
            end
         end
         default: begin
            w_ctr_reset = 1'b1;
         end
      endcase
   end

   assign w_clear_acc  = clear && w_clear_ready;
   assign w_target_acc = target_valid && w_target_ready && !w_clear_acc;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state     <= ST_INIT;
         r_phase     <= 1'b0;
         r_shadow    <= '0;
         r_target    <= '0;
         r_run_steps <= '0;
      end else begin
         // Mirror what the driven counter does on this edge.
         if (w_ctr_reset) begin
            r_shadow <= '0;
         end else if (w_ctr_inst) begin
            r_shadow <= r_shadow - 1'b1;
         end else begin
            r_shadow <= r_shadow + 1'b1;
         end

         case (r_state)
            ST_INIT: begin
               r_state <= ST_HOLD;
               r_phase <= 1'b0;
            end
            ST_HOLD: begin
               if (w_clear_acc) begin
                  r_state <= ST_CLR;
               end else if (w_target_acc) begin
                  r_state     <= ST_RUN;
                  r_target    <= target_data;
                  r_run_steps <= '0;
                  r_phase     <= 1'b0;
               end else begin
                  r_phase <= !r_phase;
               end
            end
            ST_CLR: begin
               r_state <= ST_HOLD;
               r_phase <= 1'b0;
            end
            ST_RUN: begin
               if (w_clear_acc) begin
                  r_state <= ST_CLR;
               end else if (w_at_target) begin
                  r_state <= ST_HOLD;
                  r_phase <= 1'b1;
               end else if (r_run_steps != C_STEPS_MAX) begin
                  r_run_steps <= r_run_steps + 1'b1;
               end
            end
            default: begin
               r_state <= ST_INIT;
               r_phase <= 1'b0;
            end
         endcase
      end
   end

   assign ctr_reset    = w_ctr_reset;
   assign ctr_inst     = w_ctr_inst;
   assign target_ready = w_target_ready;
   assign clear_ready  = w_clear_ready;
   assign busy         = w_busy;
   assign done         = w_done;
   assign shadow       = r_shadow;
   assign run_steps    = r_run_steps;

endmodule
`default_nettype wire

// File: doc/updown_driver.md
UPDOWN_DRIVER -- requirements
Module: updown_driver

Interface
REQ-001 Parameter: WIDTH, default 32, counter and target width in bits.
REQ-002 Port: clock  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset of this block.
REQ-004 Port: target_valid  input  1  target request valid.
REQ-005 Port: target_data  input  WIDTH  requested counter value.
REQ-006 Port: target_ready  output  1  target accepted when target_valid && target_ready at a rising edge.
REQ-007 Port: clear  input  1  request to zero the counter; sampled only when clear_ready is high.
REQ-008 Port: clear_ready  output  1  clear accepted when clear && clear_ready at a rising edge.
REQ-009 Port: ctr_reset  output  1  synchronous active-high reset to the driven up/down counter.
REQ-010 Port: ctr_inst  output  1  counter instruction: 0 = count up, 1 = count down.
REQ-011 Port: shadow  output  WIDTH  value the counter holds after the most recent edge.
REQ-012 Port: busy  output  1  high while in INIT, CLR or RUN.
REQ-013 Port: done  output  1  one-cycle pulse when shadow first equals the accepted target.
REQ-014 Port: run_steps  output  WIDTH  number of counting cycles in the last completed or current run.

Function
REQ-015 The driven counter moves every cycle unless reset, so the block SHALL always drive exactly one of: ctr_reset=1, ctr_inst=0, or ctr_inst=1.
REQ-016 shadow SHALL update each edge: 0 if ctr_reset; else shadow-1 if ctr_inst; else shadow+1; arithmetic modulo 2^WIDTH.
REQ-017 States: INIT, HOLD, CLR, RUN; ctr_reset, ctr_inst, target_ready, clear_ready, busy and done SHALL be combinational from state, phase, shadow and the target register.
REQ-018 INIT: ctr_reset=1 for one cycle -> HOLD with phase=0.
REQ-019 HOLD: dither around the held value; phase 0 drives ctr_inst=0 -> phase 1; phase 1 drives ctr_inst=1 -> phase 0; shadow equals the held value whenever phase=0.
REQ-020 target_ready and clear_ready SHALL be high only in HOLD with phase=0; clear_ready SHALL also be high in RUN.
REQ-021 Target accept: latch target_data, clear run_steps to 0 -> RUN; the accept cycle drives ctr_inst=0 (dither phase 0).
REQ-022 RUN with shadow != target: drive the direction chosen per REQ-030/031, increment run_steps.
REQ-023 RUN with shadow == target: assert done, drive ctr_inst=0, go to HOLD phase=1; the held value is the target.
REQ-024 A target equal to the current held value SHALL complete in two cycles after accept (accept edge to held+1, one down step) with run_steps=1.
REQ-025 Clear accept SHALL go to CLR (aborting RUN without done); CLR drives ctr_reset=1 for one cycle -> HOLD phase=0 with held value 0.
REQ-026 clear SHALL take priority over target_valid when both are accepted in the same cycle; the target is not accepted.
REQ-027 run_steps SHALL saturate at 2^WIDTH-1 and hold its value in HOLD.

Reset
REQ-028 Reset low SHALL immediately force state=INIT, phase=0, shadow=0, target register=0, run_steps=0, done=0.
REQ-029 Reset asserted mid-RUN SHALL abandon the run without done; the first cycle after release re-zeroes the counter via INIT.

Configuration
REQ-030 Macro SHORTEST_PATH_EN defined: direction = up if (target-shadow) mod 2^WIDTH <= (shadow-target) mod 2^WIDTH, else down; ties go up; runs may wrap through 0.
REQ-031 Macro SHORTEST_PATH_EN undefined: direction = up if target > shadow unsigned, else down; never wraps.

Verification
REQ-032 Release reset, idle 6 cycles -> ctr_reset high first cycle only; shadow sequence 0,1,0,1,0; target_ready high on phase-0 cycles.
REQ-033 Accept target 5 from held 0 -> 4 up steps after the accept edge, done pulses when shadow=5, run_steps=4, then dither 6,5.
REQ-034 Held 0, target 0xFFFFFFFE -> with SHORTEST_PATH_EN 3 down steps through wrap, run_steps=3; without, 0xFFFFFFFD up steps (use WIDTH=8: target 0xFE, 253 steps).
REQ-035 clear and target_valid asserted together in HOLD phase 0 -> CLR, ctr_reset one cycle, shadow 0, target not accepted, no done.
REQ-036 Reset pulsed low during RUN toward 100 at shadow 40 -> shadow 0 immediately, no done, INIT drives ctr_reset on the first cycle after release.
